// File: rtl/inst_mem.sv
// ---------------------------------------------------------------------------
// inst_mem
//   Synchronous instruction memory for the fetch stage. It uses a
//   registered-read RAM of 2**ADDR_W words of DATA_W bits. A byte-serial boot
//   loader fills the RAM. Fetch returns the addressed word one cycle after the
//   address is presented, and the result holds while en is low.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   a              fetch byte address (PC)
//   en             fetch enable; 0 = stall (inst/inst_valid/fault hold)
//   inst           registered instruction (0 = NOP on fault or during load)
//   inst_valid     inst holds a completed fetch
//   fault          last fetch was misaligned or beyond the memory
//   ld_start       start (or restart) a load at word 0
//   ld_byte_valid  ld_byte carries a byte this cycle
//   ld_byte        load byte, most-significant byte of each word first
//   ld_last        marks the final byte of the image
//   ld_busy        loader is in LOAD
//   ld_done        a load has completed since the last reset or ld_start
//
// Handshake: the loader has no ready signal. A byte is consumed on every edge
// where state is LOAD, ld_byte_valid=1 and ld_start=0. At any other time the
// byte is dropped, so the source must only stream while ld_busy=1.
// ---------------------------------------------------------------------------
module inst_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic              en,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fault,
  input  logic              ld_start,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [BC_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   asm_d;
  logic                done_q;
  logic [DATA_W-1:0]   inst_q;
  logic                valid_q;
  logic                fault_q;
  logic                fault_d;
  logic                word_end;
  logic                we;
  logic [ADDR_W-1:0]   idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  // The incoming byte lands in lane NB-1-cnt. The lanes below it are still
  // zero in asm_q, so a word cut short by ld_last is padded with zeros for free.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < NB; i++) begin
      if (cnt_q == BC_W'(NB - 1 - i)) asm_d[8*i +: 8] = ld_byte;
    end
  end

  assign word_end = (cnt_q == BC_W'(NB - 1)) | ld_last;
  assign we       = (state_q == S_LOAD) & ~rst & ~ld_start & ld_byte_valid & word_end;
  assign idx      = a[ADDR_W+1:2];
  assign fault_d  = (a[1:0] != 2'b00) | ((a >> (ADDR_W + 2)) != 32'd0);

  // Storage is deliberately not reset. Contents survive rst and an aborted load.
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q] <= asm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // Fetch is blocked while loading, so a read never meets a write.
          inst_q  <= '0;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
          if (ld_start) begin
            cnt_q <= '0;
            ptr_q <= '0;
            asm_q <= '0;
          end else if (ld_byte_valid) begin
            if (word_end) begin
              cnt_q <= '0;
              asm_q <= '0;
              // The pointer stops at the last word instead of wrapping.
              if (ld_last || (&ptr_q)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
              asm_q <= asm_d;
            end
          end
        end
        default: begin
          // IDLE and DONE both serve fetches.
          if (en) begin
            fault_q <= fault_d;
            inst_q  <= fault_d ? '0 : mem[idx];
            valid_q <= 1'b1;
          end
          if (ld_start) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ptr_q   <= '0;
            asm_q   <= '0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign fault      = fault_q;
  assign ld_busy    = (state_q == S_LOAD);
  assign ld_done    = done_q;

endmodule

// File: doc/inst_mem.md
# inst_mem

Parametrised, synchronous instruction memory for the pipelined CPU's fetch stage. It replaces the fixed 64-word combinational ROM with a registered-read RAM of configurable depth and width. A byte-serial boot loader fills it at run time, and fetch returns the instruction one cycle after the address. The block adds a stall hold and an address fault flag, and it sits between the PC register and the IF/ID pipeline register.

## Interface
- ADDR_W, 6, word-address bits; depth = 2**ADDR_W words
- DATA_W, 32, instruction width in bits; must be a multiple of 8
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- a  in  32  fetch byte address (the PC)
- en  in  1  fetch enable; 0 = stall, outputs hold
- inst  out  DATA_W  registered instruction
- inst_valid  out  1  inst holds a completed fetch
- fault  out  1  last fetch was misaligned or out of range
- ld_start  in  1  begin a load at word 0
- ld_byte_valid  in  1  ld_byte is valid this cycle
- ld_byte  in  8  load data, MSB byte of each word first
- ld_last  in  1  qualifies the final byte of the image
- ld_busy  out  1  loader in LOAD state
- ld_done  out  1  a load has completed since the last reset or ld_start

## Operation
- NB = DATA_W/8 bytes per word. The byte counter is ceil(log2 NB) bits. The word pointer is ADDR_W bits.
- FSM states are IDLE, LOAD and DONE. Fetch is served in IDLE and DONE only.
- IDLE/DONE on ld_start goes to LOAD. The byte counter, word pointer and assembly register clear, and ld_done clears.
- LOAD on ld_byte_valid shifts ld_byte into the assembly register from the MSB down and increments the byte counter.
- When the NB-th byte arrives, the assembled word writes to mem[word pointer]. The byte counter clears and the word pointer increments.
- LOAD ends and moves to DONE in either of two cases:
  - ld_last arrives with a byte.
  - A word writes to address 2**ADDR_W-1. The pointer does not wrap, and further bytes are ignored.
- If ld_last arrives with a partial word, the remaining low bytes pad with 0 and the word writes in that same cycle.
- ld_start in LOAD restarts the load at word 0. A byte presented in the same cycle is discarded. Words already written are kept.
- ld_byte_valid in IDLE/DONE is ignored.
- Fetch with en=1 and state IDLE/DONE samples a. The word index is a[ADDR_W+1:2].
  - fault_n = (a[1:0] != 0) | (a[31:ADDR_W+2] != 0).
  - inst <= fault_n ? 0 : mem[index]. The value 0 is a NOP.
  - inst_valid <= 1 and fault <= fault_n.
- With en=0, inst, inst_valid and fault hold their values.
- In LOAD, fetch is blocked: inst <= 0, inst_valid <= 0, fault <= 0 each cycle regardless of en. A write and a read therefore never collide.
- Memory contents are not cleared by rst. Contents are undefined until loaded.

## Timing
- Reset values: inst=0, inst_valid=0, fault=0, ld_busy=0, ld_done=0. The state goes to IDLE and all counters go to 0.
- Fetch latency is 1 cycle: the address is presented at edge N and inst is valid after edge N+1.
- ld_busy=1 from the cycle after ld_start until the cycle after the terminating byte.
- ld_done goes to 1 the cycle after termination. It holds until the next ld_start or rst.
- A word write occurs on the edge that accepts its final or ld_last byte. A fetch of that word is legal from the first cycle in DONE.
- rst during LOAD aborts at the next edge. Words already written are retained, and the partial assembly is lost.
- rst has priority over ld_start. ld_start has priority over ld_byte_valid.

## Test plan
- Reset state: assert rst for 2 cycles with ld_start=1 and en=1 -> all outputs are 0 and ld_busy stays 0.
- Load and fetch:
  - Stimulus: ld_start, then bytes 3C 00 10 00 14 00 3C 01 14 00 50 02, with ld_last on the 12th byte.
  - Expected: ld_done=1 and ld_busy=0 the cycle after the last byte.
  - Then fetch a=0, 4, 8 on consecutive cycles -> inst = 3C001000, 14003C01, 14005002, each one cycle late, with inst_valid=1.
- Stall: fetch a=4, then en=0 for 3 cycles while a changes to 8 -> inst holds 14003C01 and inst_valid stays 1.
- Faults (ADDR_W=6):
  - a=0x00000006 -> fault=1, inst=0.
  - a=0x00000100 -> fault=1, inst=0.
  - a=0x000000FC -> fault=0, inst=mem[63].
- Partial word: ld_start, then bytes AA BB with ld_last on BB -> mem[0]=AABB0000 and ld_done=1.
- Boundary conditions:
  - With ADDR_W=2, stream 20 bytes without ld_last -> DONE after byte 16, and bytes 17-20 are ignored.
  - ld_start mid-word restarts the load at word 0.
  - rst mid-load -> IDLE, ld_done=0, and earlier words remain fetchable.
